// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
// Holds the funct3 load/store encodings, the FSM state encoding, and the
// helpers that decide whether an access is legal and how it maps onto the
// four byte lanes of a memory word.
package data_mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Stores only support B/H/W; loads add the unsigned B/H forms.
    function automatic logic access_legal(logic is_store, logic [2:0] f3, logic [1:0] off);
        case (f3)
            F3_B:    return 1'b1;
            F3_H:    return ~off[0];
            F3_W:    return off == 2'b00;
            F3_BU:   return ~is_store;
            F3_HU:   return ~is_store & ~off[0];
            default: return 1'b0;
        endcase
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, otherwise word.
    function automatic logic [3:0] byte_enables(logic [1:0] size, logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow store data is replicated so every possible lane already holds it.
    function automatic logic [31:0] lane_data(logic [1:0] size, logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Word-addressed req/ack data-memory port.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : driven by the access unit
//   mem_ack/mem_rdata                         : driven by the memory
// master = access unit side, slave = memory side.
interface data_mem_access_unit_if #(
    parameter int MEM_AW = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_mem_access_unit_load_extend.sv
// Combinational load lane select and extension.
//   word : raw 32-bit memory word
//   off  : byte offset addr[1:0]
//   f3   : funct3 load encoding (B/H/W/BU/HU)
//   data : sign- or zero-extended result
module data_mem_access_unit_load_extend
    import data_mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] data
);
    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {off, 3'b000};
        case (f3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/data_mem_access_unit.sv
// Data-memory access unit: turns memRead/memWrite from the pipeline into a
// single req/ack memory transaction, returns extended load data and stalls
// the pipeline until the access finishes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   memRead, memWrite   : access request (store wins when both are set)
//   funct3, addr, wdata : access width/sign, byte address, store data
//   rdata               : load result, valid in the single DONE cycle
//   stall               : hold the pipeline
//   fault               : one-cycle pulse on illegal access or bus timeout
//   mem                 : memory port (master side)
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              fault,
    data_mem_access_unit_if.master mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic [1:0]       req_off;
    logic [2:0]       req_f3;
    logic [31:0]      load_data;
    logic             req_active;
    logic             req_legal;
    logic             expire;
    logic             unused_addr_hi;

    assign req_active     = memRead | memWrite;
    assign req_legal      = access_legal(memWrite, funct3, addr[1:0]);
    assign expire         = wait_cnt == CNT_W'(TIMEOUT - 1);
    assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW+2];

    data_mem_access_unit_load_extend u_load_extend (
        .word (mem.mem_rdata),
        .off  (req_off),
        .f3   (req_f3),
        .data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_active) begin
                    if (req_legal) begin
                        stall     = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // An ack on the final allowed cycle still counts as success.
                if (mem.mem_ack || expire) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                fault     = timed_out;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The combinational outputs must read 0 while reset is held, even if
        // the pipeline keeps presenting a request.
        if (!rst_n) begin
            stall = 1'b0;
            fault = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            rdata         <= '0;
            wait_cnt      <= '0;
            timed_out     <= 1'b0;
            req_off       <= '0;
            req_f3        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
                    if (req_active && req_legal) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= memWrite;
                        mem.mem_addr  <= addr[MEM_AW+1:2];
                        mem.mem_be    <= byte_enables(funct3[1:0], addr[1:0]);
                        mem.mem_wdata <= lane_data(funct3[1:0], wdata);
                        req_off       <= addr[1:0];
                        req_f3        <= funct3;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        rdata       <= mem.mem_we ? '0 : load_data;
                    end else if (expire) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        timed_out   <= 1'b1;
                        rdata       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rdata     <= '0;
                    timed_out <= 1'b0;
                    wait_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Responder side of the datapath's memory-control signals: consumes memRead/memWrite plus funct3/address/store data from the execute/memory stage.
- Drives a req/ack word-addressed data-memory port.
- Produces sign- or zero-extended load data and a stall to the pipeline.
- Handles byte/half/word accesses with byte enables, alignment checks and a bus-timeout abort.

Parameters:
- ADDR_W, 32, byte-address width from the datapath
- MEM_AW, 10, word-address width on the memory port (uses addr[MEM_AW+1:2])
- TIMEOUT, 15, maximum cycles in REQ waiting for mem_ack before abort (must be ≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- memRead  in  1  load request from control
- memWrite  in  1  store request from control; wins if both memRead and memWrite are high
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only)
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid while stall=0 in DONE
- stall  out  1  hold pipeline
- fault  out  1  one-cycle pulse on a misaligned access, illegal funct3 or timeout
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  MEM_AW  word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output 0; timeout counter 0. Reset mid-access drops mem_req immediately; the memory side must tolerate an abandoned request.
- States: IDLE, REQ, DONE.
- IDLE:
  - Request active (memRead|memWrite) and legal → stall=1 combinationally. At the next edge go to REQ and register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata.
  - Request illegal (H with addr[0]=1, W with addr[1:0]≠0, funct3 ∉ {000,001,010,100,101} for loads, or funct3 ∉ {000,001,010} for stores) → no memory access, stall=0, fault=1 for that cycle, rdata=0, stay in IDLE.
  - No request → stall=0.
- Byte enables / lanes:
  - B: be = 0001<<addr[1:0], wdata[7:0] replicated to all four lanes.
  - H: be = 0011<<addr[1:0], wdata[15:0] replicated to both halves.
  - W: be = 1111.
  - Loads use the same be values.
  - No read-modify-write.
- REQ:
  - stall=1; mem_req held with stable address/data until mem_ack.
  - On mem_ack:
    - Load: extract the lane by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU; register into rdata.
    - Store: rdata=0.
    - Deassert mem_req and go to DONE.
  - Counter increments each REQ cycle without ack. When the counter reaches TIMEOUT: go to DONE, rdata=0, fault pulses in DONE.
  - mem_ack in the same cycle the counter hits TIMEOUT counts as success.
- DONE:
  - Exactly one cycle: stall=0, rdata valid, pipeline advances on this edge.
  - Next state is unconditionally IDLE; the still-present request inputs are not re-issued.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): 2 stall cycles, then DONE.
  - Each wait cycle adds one stall cycle.
  - Back-to-back memory instructions: the new request is seen in IDLE the cycle after DONE.
- Pipeline contract: inputs are held stable while stall=1.
- mem_ack outside REQ is ignored.

Decomposition:
- Shared defines file gets the funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encodings.
- One natural sub-module: load_extend (combinational lane select plus sign/zero extension from mem_rdata, addr[1:0], funct3), reusable by a future instruction-fetch or cache path.

Test Plan:
- Zero-wait LW, addr=0x8, mem_rdata=0xDEADBEEF with ack in the first REQ cycle → mem_addr=2, be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE, fault=0.
- LB and LBU at addr=0x3, mem_rdata=0x80FF_0000 → be=1000; LB gives rdata=0xFFFFFF80, LBU gives 0x00000080.
- SH at addr=0x6, wdata=0x1234ABCD, 3 wait cycles → mem_we=1, be=1100, mem_wdata=0xABCDABCD stable 4 REQ cycles, stall high 5 cycles total.
- LW at addr=0x5 → no mem_req, stall=0, fault high 1 cycle; SH at addr=0x1 gives the same result.
- No ack for TIMEOUT=15 cycles → mem_req drops after 15 REQ cycles, DONE with rdata=0 and fault=1, then IDLE.
- rst_n pulled low during REQ → mem_req, stall and rdata go to 0 asynchronously; after release, a fresh LW completes normally.
